// File: rtl/alien_fire_scheduler_pkg.sv
// params: formation geometry, fire-scheduler state encoding and cooldown default
package params;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 8;
    localparam int COOLDOWN_FRAMES = 30;
    typedef enum logic [1:0] {IDLE, PICK, SCAN, ISSUE} fire_state_t;
endpackage

// File: rtl/alien_fire_scheduler_column_shooter_select.sv
// column_shooter_select: finds the living alien nearest the player in one column
module column_shooter_select #(
    parameter int NUM_ROWS = params::NUM_ROWS,
    parameter int NUM_COLS = params::NUM_COLS
) (
    input  logic [$clog2(NUM_COLS)-1:0]  col,
    input  logic [NUM_ROWS*NUM_COLS-1:0] alive,
    output logic                         found,
    output logic [$clog2(NUM_ROWS)-1:0]  row
);
    localparam int RW = $clog2(NUM_ROWS);
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] grid;
    logic [NUM_ROWS-1:0] hit;
    assign grid = alive;
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_hit
        assign hit[r] = grid[r][col];
    end
    // later rows overwrite earlier ones, so the highest living row wins
    always_comb begin
        found = |hit;
        row = '0;
        for (int r = 0; r < NUM_ROWS; r++) row = hit[r] ? RW'(r) : row;
    end
endmodule

// File: rtl/alien_fire_scheduler.sv
// alien_fire_scheduler: picks when the formation fires, which alien shoots and which bullet slot carries it
module alien_fire_scheduler #(
    parameter int NUM_ROWS        = params::NUM_ROWS,
    parameter int NUM_COLS        = params::NUM_COLS,
    parameter int NUM_SLOTS       = 3,
    parameter int COOLDOWN_FRAMES = params::COOLDOWN_FRAMES
) (
    input  logic                          pixel_clk,
    input  logic                          rst,
    input  logic                          fsync,
    input  logic                          enable,
    input  logic [NUM_ROWS*NUM_COLS-1:0]  alien_alive,
    input  logic [NUM_SLOTS-1:0]          slot_busy,
    input  logic [15:0]                   rnd,
    output logic                          fire_valid,
    input  logic                          fire_ack,
    output logic [$clog2(NUM_SLOTS)-1:0]  fire_slot,
    output logic [$clog2(NUM_ROWS)-1:0]   fire_row,
    output logic [$clog2(NUM_COLS)-1:0]   fire_col
);
    import params::*;
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    fire_state_t state_q, state_d;
    logic [7:0] cooldown_q, cooldown_d, reload_val;
    logic [SW-1:0] slot_q, slot_d, free_slot;
    logic [RW-1:0] row_q, row_d, sel_row;
    logic [CW-1:0] col_q, col_d, scan_col_q, scan_col_d, cnt_q, cnt_d;
    logic sel_found, attempt, reload, rnd_unused;
    assign rnd_unused = ^{rnd[15:12], rnd[7:0]};
    column_shooter_select #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS)) u_sel (
        .col(scan_col_q),
        .alive(alien_alive),
        .found(sel_found),
        .row(sel_row)
    );
    always_comb begin
        free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) free_slot = slot_busy[i] ? free_slot : SW'(i);
    end
    // a thinned-out formation fires twice as often
    assign reload_val = ($countones(alien_alive) > NUM_ROWS * NUM_COLS / 2) ?
                        8'(COOLDOWN_FRAMES) : 8'(COOLDOWN_FRAMES >> 1);
    assign attempt = fsync && enable && cooldown_q == 8'd0 && !(&slot_busy);
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cooldown_q <= 8'(COOLDOWN_FRAMES);
            slot_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            scan_col_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cooldown_q <= cooldown_d;
            slot_q     <= slot_d;
            row_q      <= row_d;
            col_q      <= col_d;
            scan_col_q <= scan_col_d;
            cnt_q      <= cnt_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        row_d      = row_q;
        col_d      = col_q;
        scan_col_d = scan_col_q;
        cnt_d      = cnt_q;
        reload     = 1'b0;
        if (state_q != IDLE && !enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = attempt ? PICK : IDLE;
                PICK: begin
                    slot_d     = free_slot;
                    scan_col_d = CW'(32'(rnd[11:8]) % NUM_COLS);
                    cnt_d      = '0;
                    state_d    = SCAN;
                end
                SCAN: begin
                    if (sel_found) begin
                        row_d   = sel_row;
                        col_d   = scan_col_q;
                        state_d = ISSUE;
                    end else begin
                        scan_col_d = (scan_col_q == CW'(NUM_COLS - 1)) ? '0 : scan_col_q + 1'b1;
                        cnt_d      = cnt_q + 1'b1;
                        state_d    = (cnt_q == CW'(NUM_COLS - 1)) ? IDLE : SCAN;
                    end
                end
                ISSUE: begin
                    reload  = fire_ack;
                    state_d = (fire_ack || slot_busy[slot_q]) ? IDLE : ISSUE;
                end
                default: state_d = IDLE;
            endcase
        end
        // reload beats a coincident frame decrement
        cooldown_d = reload ? reload_val :
                     (fsync && cooldown_q != 8'd0) ? cooldown_q - 8'd1 : cooldown_q;
    end
    always_comb begin
        fire_valid = state_q == ISSUE;
        fire_slot  = slot_q;
        fire_row   = row_q;
        fire_col   = col_q;
    end
endmodule

// File: tb/tb_alien_fire_scheduler.sv
// tb_alien_fire_scheduler: directed and randomized checks against a transaction-level fire model
module tb_alien_fire_scheduler;
    logic pixel_clk = 1'b0;
    logic rst = 1'b1, fsync = 1'b0, enable = 1'b1, fire_ack = 1'b0;
    logic [31:0] alien_alive = '1;
    logic [2:0] slot_busy = '0;
    logic [15:0] rnd = '0;
    logic fire_valid;
    logic [1:0] fire_slot, fire_row;
    logic [2:0] fire_col;
    int n_tests = 0, n_fail = 0, m_cd = 4;
    bit e_fire;
    int e_lat, e_slot, e_row, e_col;

    alien_fire_scheduler #(.COOLDOWN_FRAMES(4)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .enable(enable),
        .alien_alive(alien_alive), .slot_busy(slot_busy), .rnd(rnd),
        .fire_valid(fire_valid), .fire_ack(fire_ack), .fire_slot(fire_slot),
        .fire_row(fire_row), .fire_col(fire_col)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outcome of one attempt, straight from the firing rules.
    function automatic void model_shot(input logic [31:0] alive, input logic [2:0] busy,
                                       input logic [15:0] r, output bit fire, output int lat,
                                       output int slot, output int row, output int col);
        int start;
        slot = -1;
        for (int i = 0; i < 3; i++) if (!busy[i] && slot < 0) slot = i;
        fire = 0; lat = 0; row = 0; col = 0;
        if (slot < 0) return;
        start = int'(r[11:8]) % 8;
        for (int k = 0; k < 8 && !fire; k++) begin
            for (int rr = 0; rr < 4; rr++) begin
                if (alive[rr * 8 + (start + k) % 8]) begin
                    fire = 1; row = rr; col = (start + k) % 8; lat = 3 + k;
                end
            end
        end
    endfunction

    task automatic fs_pulse();
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
        if (m_cd > 0) m_cd--;
        repeat (3) tick();
        chk("cooldown_no_fire", 32'(fire_valid), 0);
        chk("cooldown_count", 32'(dut.cooldown_q), 32'(m_cd));
    endtask

    task automatic expect_attempt(input string tag, input bit fire, input int lat,
                                  input int slot, input int row, input int col);
        int n;
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
        n = 1;
        if (fire) begin
            while (!fire_valid && n < lat + 2) begin
                tick();
                n++;
            end
            chk({tag, "_latency"}, 32'(n), 32'(lat));
            chk({tag, "_slot"}, 32'(fire_slot), 32'(slot));
            chk({tag, "_row"}, 32'(fire_row), 32'(row));
            chk({tag, "_col"}, 32'(fire_col), 32'(col));
        end else begin
            for (int i = 0; i < 9; i++) begin
                chk({tag, "_no_fire"}, 32'(fire_valid), 0);
                tick();
            end
        end
    endtask

    task automatic model_attempt(input string tag);
        model_shot(alien_alive, slot_busy, rnd, e_fire, e_lat, e_slot, e_row, e_col);
        expect_attempt(tag, e_fire, e_lat, e_slot, e_row, e_col);
    endtask

    task automatic do_ack(input bit with_fs);
        fire_ack = 1'b1;
        fsync = with_fs;
        m_cd = ($countones(alien_alive) > 16) ? 4 : 2;
        tick();
        fire_ack = 1'b0;
        fsync = 1'b0;
        chk("ack_valid_drop", 32'(fire_valid), 0);
        chk("ack_reload", 32'(dut.cooldown_q), 32'(m_cd));
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_valid", 32'(fire_valid), 0);
        chk("rst_slot", 32'(fire_slot), 0);
        chk("rst_row", 32'(fire_row), 0);
        chk("rst_col", 32'(fire_col), 0);
        chk("rst_cooldown", 32'(dut.cooldown_q), 4);
        rst = 1'b0;
        tick();
        // first shot after the grace period
        rnd = 16'h0500;
        while (m_cd > 0) fs_pulse();
        expect_attempt("first", 1, 3, 0, 3, 5);
        do_ack(0);
        // empty start column, then fsync coincident with ack
        alien_alive = '1;
        alien_alive[5] = 0; alien_alive[13] = 0; alien_alive[21] = 0; alien_alive[29] = 0;
        alien_alive[22] = 0; alien_alive[30] = 0;
        while (m_cd > 0) fs_pulse();
        expect_attempt("skip_col", 1, 4, 0, 1, 6);
        do_ack(1);
        chk("coincide_cd4", 32'(dut.cooldown_q), 4);
        // wrap from column 7 to column 0, then abort in ISSUE
        alien_alive = 32'h0001_0000;
        rnd = 16'h0700;
        while (m_cd > 0) fs_pulse();
        expect_attempt("wrap", 1, 4, 0, 2, 0);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        chk("abort_issue_valid", 32'(fire_valid), 0);
        chk("abort_issue_cd", 32'(dut.cooldown_q), 0);
        // all dead: full scan, back in IDLE in time to take the next fsync
        alien_alive = '0;
        expect_attempt("all_dead", 0, 0, 0, 0, 0);
        alien_alive = 32'h0001_0000;
        expect_attempt("retry", 1, 4, 0, 2, 0);
        do_ack(0);
        fire_ack = 1'b1;
        tick();
        fire_ack = 1'b0;
        chk("idle_ack_ignored", 32'(dut.cooldown_q), 2);
        // slot priority and slot loss before ack
        alien_alive = '1;
        rnd = 16'h0000;
        slot_busy = 3'b011;
        while (m_cd > 0) fs_pulse();
        expect_attempt("slot2", 1, 3, 2, 3, 0);
        slot_busy = 3'b111;
        tick();
        chk("slot_lost_valid", 32'(fire_valid), 0);
        chk("slot_lost_cd", 32'(dut.cooldown_q), 0);
        expect_attempt("all_busy", 0, 0, 0, 0, 0);
        chk("all_busy_cd", 32'(dut.cooldown_q), 0);
        slot_busy = 3'b000;
        // half-rate reload: shot again on the third fsync
        alien_alive = 32'hFFFF_0000;
        expect_attempt("half", 1, 3, 0, 3, 0);
        do_ack(0);
        chk("half_reload", 32'(dut.cooldown_q), 2);
        fs_pulse();
        fs_pulse();
        expect_attempt("half_third", 1, 3, 0, 3, 0);
        do_ack(0);
        // abort during SCAN
        while (m_cd > 0) fs_pulse();
        alien_alive = 32'h0000_0080;
        rnd = 16'h0200;
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
        repeat (2) tick();
        enable = 1'b0;
        tick();
        chk("abort_scan_valid", 32'(fire_valid), 0);
        repeat (6) tick();
        chk("abort_scan_late", 32'(fire_valid), 0);
        enable = 1'b1;
        chk("abort_scan_cd", 32'(dut.cooldown_q), 0);
        // randomized attempts against the model
        for (int it = 0; it < 60; it++) begin
            alien_alive = $urandom;
            if (it % 3 == 1) alien_alive &= $urandom & $urandom & $urandom;
            if (it % 10 == 7) alien_alive = '0;
            slot_busy = 3'($urandom);
            if (it % 4 != 0 && &slot_busy) slot_busy = 3'b101;
            rnd = 16'($urandom);
            while (m_cd > 0) fs_pulse();
            model_attempt("rand");
            if (e_fire) begin
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    chk("rand_hold_valid", 32'(fire_valid), 1);
                    chk("rand_hold_col", 32'(fire_col), 32'(e_col));
                end
                case ($urandom_range(0, 4))
                    0: begin
                        enable = 1'b0;
                        tick();
                        enable = 1'b1;
                        chk("rand_abort_valid", 32'(fire_valid), 0);
                        chk("rand_abort_cd", 32'(dut.cooldown_q), 32'(m_cd));
                    end
                    1: begin
                        slot_busy[e_slot] = 1'b1;
                        tick();
                        chk("rand_lost_valid", 32'(fire_valid), 0);
                        chk("rand_lost_cd", 32'(dut.cooldown_q), 32'(m_cd));
                    end
                    default: do_ack(1'($urandom_range(0, 1)));
                endcase
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
